sim_watchdog: RTL and testbench
===============================

Name: sim_watchdog

Overview:
- Testbench-side supervisor. Consumes the clock and active-low reset from the clock/reset generator and tracks simulation progress.
- Counts cycles since reset release, waits a warm-up window, then watches DUT activity pulses. Latches either successful completion or a timeout (stall or global cycle budget exhausted).
- Sits between clock/reset generation and the scoreboard/end-of-test logic; its sticky status outputs terminate the run.

Parameters:
- CNT_W, 32, width of all cycle counters.
- WARMUP_CYCLES, 4, cycles spent in WARMUP before monitoring starts (0 allowed).
- STALL_CYCLES, 1000, consecutive cycles without progress_i that trigger a stall timeout (must be >= 1).
- MAX_CYCLES, 1000000, total RUN cycles allowed before a budget timeout (must be >= 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- start_i  in  1  arms the watchdog; sampled in IDLE only.
- progress_i  in  1  one-cycle activity pulse from the DUT, e.g. any valid&ready handshake.
- done_i  in  1  test-complete indication from the scoreboard.
- running_o  out  1  high in WARMUP and RUN.
- done_o  out  1  sticky completion flag.
- timeout_o  out  1  sticky failure flag.
- err_o  out  2  failure cause: 00 none, 01 stall, 10 budget.
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed; saturating.
- stall_cnt_o  out  CNT_W  current consecutive no-progress cycles.

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is synchronous and active-low; the block acts on it at the clk_i rising edge only.
- Reset values: state IDLE, all counters 0, running_o=0, done_o=0, timeout_o=0, err_o=00.
- Reset asserted mid-operation returns the block to IDLE at the next edge and clears all outputs, including sticky flags.
- States are IDLE, WARMUP, RUN, DONE, TIMEOUT. All outputs are registered and reflect the state after the edge.
- IDLE:
  - start_i=1 moves to WARMUP and loads the warm-up counter with 0.
  - If WARMUP_CYCLES=0, start_i moves directly to RUN.
- WARMUP:
  - The counter increments each cycle.
  - When it reaches WARMUP_CYCLES-1, the next state is RUN.
  - progress_i and done_i are ignored in WARMUP.
- RUN, evaluated in this priority order each cycle:
  1. done_i=1 -> DONE, done_o=1.
  2. stall_cnt_o==STALL_CYCLES-1 and progress_i=0 -> TIMEOUT, err_o=01.
  3. cycle_cnt_o==MAX_CYCLES-1 -> TIMEOUT, err_o=10.
  4. Otherwise stay in RUN.
- Counters in RUN:
  - cycle_cnt_o increments every RUN cycle and saturates at 2^CNT_W-1.
  - stall_cnt_o clears to 0 on progress_i=1, otherwise increments; it also saturates.
  - Entry into RUN clears both counters.
- Simultaneous events:
  - done_i wins over any timeout in the same cycle.
  - progress_i in the stall-limit cycle prevents the stall timeout.
  - When stall and budget limits coincide, stall (01) is reported.
- DONE and TIMEOUT are terminal until reset. Counters freeze and start_i is ignored.
- Latency: done_i or the timeout condition at edge N appears on the outputs immediately after edge N (1 cycle).

Optional Feature:
- Macro: SIM_WATCHDOG_FINISH_EN.
- Defined: on entry to DONE, print "PASS" with cycle_cnt_o and call $finish. On entry to TIMEOUT, $error with err_o and cycle_cnt_o, then $finish(1). Each action fires exactly once per entry.
- Undefined: no system tasks are called; only the flags are driven and the bench decides what to do.

Decomposition:
- Package sim_watchdog_pkg holds:
  - state enum (IDLE, WARMUP, RUN, DONE, TIMEOUT), 3 bits;
  - err enum (ERR_NONE=00, ERR_STALL=01, ERR_BUDGET=10);
  - default CNT_W localparam.
- One sub-module, sat_counter (parameter W): clear, enable, saturating increment, value out. Instantiated for cycle_cnt and stall_cnt; the warm-up counter reuses it.

Test Plan:
- STALL_CYCLES=8, WARMUP_CYCLES=4. start_i at cycle 0, no progress_i -> running_o for 4+8 cycles, then timeout_o=1, err_o=01, stall_cnt_o=7.
- progress_i every 5 cycles, done_i after cycle_cnt_o=20 -> done_o=1, timeout_o=0, cycle_cnt_o frozen at 20, stall_cnt_o never exceeds 4.
- MAX_CYCLES=16, progress_i every cycle -> timeout_o=1 with err_o=10 after 16 RUN cycles.
- done_i and the stall limit in the same cycle -> done_o=1, err_o=00. Separately, progress_i in the stall-limit cycle -> stays in RUN and stall_cnt_o=0.
- rst_ni low for 1 cycle while in RUN with cycle_cnt_o=10 -> next edge IDLE, all outputs 0. A later start_i restarts WARMUP cleanly.
- CNT_W=4, STALL_CYCLES=1000, MAX_CYCLES=1000, progress_i every cycle -> cycle_cnt_o saturates at 15 without wrapping.

Source files
------------

// File: rtl/sim_watchdog_pkg.sv
// Shared types and constants for the simulation watchdog.
// Holds the FSM state encoding, the failure-cause encoding and a helper
// that turns a cycle count into the index of its last cycle.
package sim_watchdog_pkg;

    // Default width of every cycle counter in the watchdog.
    localparam int unsigned DEF_CNT_W = 32;

    // Watchdog life cycle; DONE and TIMEOUT are terminal until reset.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    // Failure cause reported alongside the timeout flag.
    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_STALL  = 2'b01,
        ERR_BUDGET = 2'b10
    } err_e;

    // Index of the last cycle of an n-cycle window, in a 64-bit domain so
    // limits wider than the counter never alias onto small counter values.
    function automatic logic [63:0] last_index(input int unsigned n);
        logic [63:0] wide;
        wide = 64'(n);
        return (n == 0) ? 64'd0 : wide - 64'd1;
    endfunction

endpackage : sim_watchdog_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over enable; once all ones the value holds instead of
// wrapping. Reset is synchronous and active-low.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] ALL_ONE = '1;

    // Count up on enable, stop at all ones, clear on request.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of block ordering.
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != ALL_ONE)) begin
            cnt_o <= cnt_o + ONE;
        end
    end

endmodule : sat_counter

// File: rtl/sim_watchdog.sv
// Simulation watchdog: waits a warm-up window after start, then supervises
// DUT progress pulses and latches either completion or a timeout (stall or
// global cycle budget). All status outputs are registered and sticky until
// reset.
//
// Optional feature, macro SIM_WATCHDOG_FINISH_EN: when defined, entering
// DONE prints PASS and ends the simulation, entering TIMEOUT raises $error
// and ends it with a non-zero diagnostic level. When undefined the block
// only drives its flags.
//
// Limits are compared in a 64-bit domain, so CNT_W must not exceed 64.
module sim_watchdog
    import sim_watchdog_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned WARMUP_CYCLES = 4,
    parameter int unsigned STALL_CYCLES  = 1000,
    parameter int unsigned MAX_CYCLES    = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             progress_i,
    input  logic             done_i,
    output logic             running_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [1:0]       err_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [63:0] WARM_LAST  = last_index(WARMUP_CYCLES);
    localparam logic [63:0] STALL_LAST = last_index(STALL_CYCLES);
    localparam logic [63:0] CYCLE_LAST = last_index(MAX_CYCLES);
    localparam bit          SKIP_WARM  = (WARMUP_CYCLES == 0);

    state_e           state;
    logic [CNT_W-1:0] warm_cnt;

    logic warm_last;
    logic stall_last;
    logic cycle_last;
    logic stall_hit;
    logic budget_hit;
    logic run_exit;
    logic run_stay;
    logic enter_run;
    logic warm_clr;
    logic warm_en;
    logic cyc_clr;
    logic cyc_en;
    logic stall_clr;
    logic stall_en;

    // Limit detection and counter controls derived from the current state.
    always_comb begin
        // NOTE: every signal gets a value on every path through this block;
        // a missed assignment would infer a latch.
        warm_last  = (64'(warm_cnt) == WARM_LAST);
        stall_last = (64'(stall_cnt_o) == STALL_LAST);
        cycle_last = (64'(cycle_cnt_o) == CYCLE_LAST);

        // Progress in the limit cycle rescues the stall; done_i beats both.
        stall_hit  = stall_last && !progress_i;
        budget_hit = cycle_last;
        run_exit   = (state == ST_RUN) && (done_i || stall_hit || budget_hit);
        run_stay   = (state == ST_RUN) && !run_exit;

        enter_run  = ((state == ST_IDLE) && start_i && SKIP_WARM) ||
                     ((state == ST_WARMUP) && warm_last);

        // The warm-up counter idles at zero so it starts from 0 on start_i.
        warm_clr   = (state == ST_IDLE);
        warm_en    = (state == ST_WARMUP);

        // Counters freeze on the exit edge and in the terminal states.
        cyc_clr    = enter_run;
        cyc_en     = run_stay;
        stall_clr  = enter_run || (run_stay && progress_i);
        stall_en   = run_stay && !progress_i;
    end

    sat_counter #(.W(CNT_W)) u_warm_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (warm_clr),
        .en_i   (warm_en),
        .cnt_o  (warm_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cyc_clr),
        .en_i   (cyc_en),
        .cnt_o  (cycle_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (stall_clr),
        .en_i   (stall_en),
        .cnt_o  (stall_cnt_o)
    );

    // Watchdog FSM with registered status flags reflecting the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            running_o <= 1'b0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            err_o     <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state     <= SKIP_WARM ? ST_RUN : ST_WARMUP;
                        running_o <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (warm_last) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (done_i) begin
                        state     <= ST_DONE;
                        running_o <= 1'b0;
                        done_o    <= 1'b1;
                    end else if (stall_hit) begin
                        state     <= ST_TIMEOUT;
                        running_o <= 1'b0;
                        timeout_o <= 1'b1;
                        err_o     <= ERR_STALL;
                    end else if (budget_hit) begin
                        state     <= ST_TIMEOUT;
                        running_o <= 1'b0;
                        timeout_o <= 1'b1;
                        err_o     <= ERR_BUDGET;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    // Terminal: hold flags and counters until reset.
                end
                default: begin
                    state     <= ST_IDLE;
                    running_o <= 1'b0;
                    done_o    <= 1'b0;
                    timeout_o <= 1'b0;
                    err_o     <= ERR_NONE;
                end
            endcase
        end
    end

`ifdef SIM_WATCHDOG_FINISH_EN
    state_e prev_state;

    // Detect entry into a terminal state once and end the simulation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_state <= ST_IDLE;
        end else begin
            prev_state <= state;
            if ((state == ST_DONE) && (prev_state != ST_DONE)) begin
                $display("PASS: sim_watchdog done after %0d run cycles", cycle_cnt_o);
                $finish;
            end
            if ((state == ST_TIMEOUT) && (prev_state != ST_TIMEOUT)) begin
                $error("sim_watchdog timeout: err=%b after %0d run cycles", err_o, cycle_cnt_o);
                $finish(1);
            end
        end
    end
`else
    // Flags only; whoever watches done_o/timeout_o decides how to end the run.
`endif

endmodule : sim_watchdog

// File: tb/tb_sim_watchdog.sv
// Directed testbench for sim_watchdog. Three instances cover the parameter
// sets: A (warm-up 4, stall 8), B (budget 16) and C (4-bit counters, no
// warm-up). Inputs change 1 time unit after the rising edge and outputs are
// sampled at the same point, well away from the next active edge.
module tb_sim_watchdog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic progress;
    logic done;
    logic start_a;
    logic start_b;
    logic start_c;

    logic        running_a, done_a, timeout_a;
    logic [1:0]  err_a;
    logic [31:0] cyc_a, stall_a;

    logic        running_b, done_b, timeout_b;
    logic [1:0]  err_b;
    logic [31:0] cyc_b, stall_b;

    logic        running_c, done_c, timeout_c;
    logic [1:0]  err_c;
    logic [3:0]  cyc_c, stall_c;

    sim_watchdog #(
        .CNT_W(32), .WARMUP_CYCLES(4), .STALL_CYCLES(8), .MAX_CYCLES(1000000)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .progress_i(progress),
        .done_i(done), .running_o(running_a), .done_o(done_a),
        .timeout_o(timeout_a), .err_o(err_a), .cycle_cnt_o(cyc_a),
        .stall_cnt_o(stall_a)
    );

    sim_watchdog #(
        .CNT_W(32), .WARMUP_CYCLES(4), .STALL_CYCLES(1000), .MAX_CYCLES(16)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .progress_i(progress),
        .done_i(done), .running_o(running_b), .done_o(done_b),
        .timeout_o(timeout_b), .err_o(err_b), .cycle_cnt_o(cyc_b),
        .stall_cnt_o(stall_b)
    );

    sim_watchdog #(
        .CNT_W(4), .WARMUP_CYCLES(0), .STALL_CYCLES(1000), .MAX_CYCLES(1000)
    ) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .progress_i(progress),
        .done_i(done), .running_o(running_c), .done_o(done_c),
        .timeout_o(timeout_c), .err_o(err_c), .cycle_cnt_o(cyc_c),
        .stall_cnt_o(stall_c)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        progress = 1'b0;
        done     = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic check_a_idle(input string tag);
        check({tag, ".running"}, 64'(running_a), 64'd0);
        check({tag, ".done"},    64'(done_a),    64'd0);
        check({tag, ".timeout"}, 64'(timeout_a), 64'd0);
        check({tag, ".err"},     64'(err_a),     64'd0);
        check({tag, ".cycle"},   64'(cyc_a),     64'd0);
        check({tag, ".stall"},   64'(stall_a),   64'd0);
    endtask

    // Start instance A and advance to its first RUN cycle (counters at 0).
    task automatic start_a_to_run();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(4);
    endtask

    initial begin
        int          runs;
        logic [31:0] max_stall;

        // Reset state.
        do_reset();
        tick(1);
        check_a_idle("reset");

        // Stall timeout: 4 warm-up + 8 RUN cycles, then err=01, stall=7.
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        runs = 0;
        for (int i = 0; i < 40 && running_a; i++) begin
            runs++;
            tick(1);
        end
        check("stall.running_cycles", 64'(runs),      64'd12);
        check("stall.timeout",        64'(timeout_a), 64'd1);
        check("stall.err",            64'(err_a),     64'd1);
        check("stall.stall_cnt",      64'(stall_a),   64'd7);
        check("stall.cycle_cnt",      64'(cyc_a),     64'd7);
        check("stall.done",           64'(done_a),    64'd0);
        start_a  = 1'b1;
        progress = 1'b1;
        tick(3);
        start_a  = 1'b0;
        progress = 1'b0;
        check("stall.sticky_timeout", 64'(timeout_a), 64'd1);
        check("stall.frozen_stall",   64'(stall_a),   64'd7);
        check("stall.no_restart",     64'(running_a), 64'd0);

        // Completion: progress every 5 cycles, done at cycle_cnt=20.
        do_reset();
        check_a_idle("reset2");
        start_a_to_run();
        max_stall = '0;
        for (int k = 0; k <= 20; k++) begin
            progress = (k % 5 == 4);
            done     = (k == 20);
            if (stall_a > max_stall) max_stall = stall_a;
            if (k == 10) check("done.cycle_mid", 64'(cyc_a), 64'd10);
            tick(1);
        end
        progress = 1'b0;
        done     = 1'b0;
        check("done.max_stall", 64'(max_stall), 64'd4);
        check("done.done",      64'(done_a),    64'd1);
        check("done.timeout",   64'(timeout_a), 64'd0);
        check("done.err",       64'(err_a),     64'd0);
        check("done.cycle",     64'(cyc_a),     64'd20);
        check("done.running",   64'(running_a), 64'd0);
        tick(3);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        check("done.frozen_cycle", 64'(cyc_a),  64'd20);
        check("done.sticky",       64'(done_a), 64'd1);

        // done_i coincides with the stall-limit cycle: done wins.
        do_reset();
        start_a_to_run();
        tick(7);
        check("tie.stall_at_limit", 64'(stall_a), 64'd7);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check("tie.done",    64'(done_a),    64'd1);
        check("tie.timeout", 64'(timeout_a), 64'd0);
        check("tie.err",     64'(err_a),     64'd0);

        // Progress in the stall-limit cycle rescues the run.
        do_reset();
        start_a_to_run();
        tick(7);
        progress = 1'b1;
        tick(1);
        progress = 1'b0;
        check("rescue.running", 64'(running_a), 64'd1);
        check("rescue.timeout", 64'(timeout_a), 64'd0);
        check("rescue.stall",   64'(stall_a),   64'd0);
        check("rescue.cycle",   64'(cyc_a),     64'd8);
        tick(1);
        check("rescue.stall_next", 64'(stall_a), 64'd1);

        // Reset mid-RUN clears everything; a later start restarts cleanly.
        do_reset();
        start_a_to_run();
        progress = 1'b1;
        tick(10);
        check("midrst.cycle_before", 64'(cyc_a), 64'd10);
        rst_n = 1'b0;
        tick(1);
        rst_n    = 1'b1;
        progress = 1'b0;
        check_a_idle("midrst");
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        check("midrst.restart_running", 64'(running_a), 64'd1);
        tick(4);
        check("midrst.run_running", 64'(running_a), 64'd1);
        check("midrst.run_cycle",   64'(cyc_a),     64'd0);
        check("midrst.run_stall",   64'(stall_a),   64'd0);

        // Budget timeout: 16 RUN cycles with constant progress, err=10.
        do_reset();
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        tick(4);
        check("budget.run_entry_cycle", 64'(cyc_b), 64'd0);
        progress = 1'b1;
        runs = 0;
        while (!timeout_b && runs < 100) begin
            tick(1);
            runs++;
        end
        progress = 1'b0;
        check("budget.run_cycles", 64'(runs),      64'd16);
        check("budget.timeout",    64'(timeout_b), 64'd1);
        check("budget.err",        64'(err_b),     64'd2);
        check("budget.cycle",      64'(cyc_b),     64'd15);
        check("budget.stall",      64'(stall_b),   64'd0);
        check("budget.running",    64'(running_b), 64'd0);

        // 4-bit counters, no warm-up: cycle count saturates at 15.
        do_reset();
        start_c = 1'b1;
        tick(1);
        start_c = 1'b0;
        check("sat.direct_run", 64'(running_c), 64'd1);
        check("sat.cycle0",     64'(cyc_c),     64'd0);
        progress = 1'b1;
        tick(15);
        check("sat.cycle15", 64'(cyc_c), 64'd15);
        tick(5);
        progress = 1'b0;
        check("sat.hold",    64'(cyc_c),     64'd15);
        check("sat.running", 64'(running_c), 64'd1);
        check("sat.timeout", 64'(timeout_c), 64'd0);
        check("sat.stall",   64'(stall_c),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sim_watchdog
